// File: rtl/dvp_tx_pkg.sv
// Shared types, timing defaults and colour-bar table for the DVP transmitter.
package dvp_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBP,
        ST_ACT,
        ST_VFP
    } state_t;

    localparam int DEF_H_ACT    = 640;
    localparam int DEF_H_BLANK  = 144;
    localparam int DEF_V_ACT    = 480;
    localparam int DEF_VS_LINES = 3;
    localparam int DEF_V_BP     = 17;
    localparam int DEF_V_FP     = 10;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // RGB565 full-scale bars, left to right
    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        unique case (idx)
            3'd0: c = 16'hFFFF;
            3'd1: c = 16'hFFE0;
            3'd2: c = 16'h07FF;
            3'd3: c = 16'h07E0;
            3'd4: c = 16'hF81F;
            3'd5: c = 16'hF800;
            3'd6: c = 16'h001F;
            3'd7: c = 16'h0000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dvp_tx_timing_gen.sv
// Line/frame counters and frame FSM for the DVP transmitter.
// Produces active-window and even-slot strobes plus the end-of-frame strobe.
module dvp_timing_gen
    import dvp_tx_pkg::*;
#(
    parameter int H_ACT    = DEF_H_ACT,
    parameter int H_BLANK  = DEF_H_BLANK,
    parameter int V_ACT    = DEF_V_ACT,
    parameter int VS_LINES = DEF_VS_LINES,
    parameter int V_BP     = DEF_V_BP,
    parameter int V_FP     = DEF_V_FP
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output state_t state,
    output logic   active,
    output logic   even,
    output logic   frame_end
);

    localparam int HTOT = 2 * H_ACT + H_BLANK;
    localparam int HW   = $clog2(HTOT);
    localparam int VMAX = max2(max2(VS_LINES, V_BP), max2(V_ACT, V_FP));
    localparam int VW   = $clog2(VMAX + 1);

    state_t          nxt;
    logic [HW-1:0]   hcnt;
    logic [VW-1:0]   vcnt;
    logic [VW-1:0]   lines;
    logic            line_end;
    logic            last_line;

    assign line_end  = (hcnt == HW'(HTOT - 1));
    assign last_line = (vcnt == lines - VW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    // vcnt restarts at every state change, so it counts lines within the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (state == ST_IDLE) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (line_end) begin
            hcnt <= '0;
            vcnt <= last_line ? '0 : vcnt + VW'(1);
        end else begin
            hcnt <= hcnt + HW'(1);
        end
    end

    always_comb begin
        lines = VW'(1);
        unique case (state)
            ST_VSYNC: lines = VW'(VS_LINES);
            ST_VBP:   lines = VW'(V_BP);
            ST_ACT:   lines = VW'(V_ACT);
            ST_VFP:   lines = VW'(V_FP);
            default:  lines = VW'(1);
        endcase
    end

    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE:  if (en) nxt = ST_VSYNC;
            ST_VSYNC: if (line_end && last_line) nxt = ST_VBP;
            ST_VBP:   if (line_end && last_line) nxt = ST_ACT;
            ST_ACT:   if (line_end && last_line) nxt = ST_VFP;
            ST_VFP: begin
                if (line_end && last_line) begin
                    nxt = en ? ST_VSYNC : ST_IDLE;
                end
            end
            default:  nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        active    = (state == ST_ACT) && (hcnt < HW'(2 * H_ACT));
        even      = active && !hcnt[0];
        frame_end = (state == ST_VFP) && line_end && last_line;
    end

endmodule

// File: rtl/dvp_tx.sv
// DVP transmitter: RGB565 stream in, vsync/href/byte-wide data out, high byte first.
// Optional colour-bar generator under DVP_TX_TEST_PATTERN_EN.
module dvp_tx
    import dvp_tx_pkg::*;
#(
    parameter int H_ACT    = DEF_H_ACT,
    parameter int H_BLANK  = DEF_H_BLANK,
    parameter int V_ACT    = DEF_V_ACT,
    parameter int VS_LINES = DEF_VS_LINES,
    parameter int V_BP     = DEF_V_BP,
    parameter int V_FP     = DEF_V_FP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
`ifdef DVP_TX_TEST_PATTERN_EN
    input  logic        pat_en,
`endif
    input  logic [15:0] din,
    input  logic        din_vld,
    input  logic        din_sop,
    input  logic        din_eop,
    output logic        din_rdy,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  dout,
    output logic        frame_done,
    output logic        err_udr,
    output logic        err_eop
);

    localparam int NPIX  = H_ACT * V_ACT;
    localparam int PW    = $clog2(NPIX + 1);
    localparam bit MULTI = (NPIX > 1);

    state_t          state;
    logic            active;
    logic            even;
    logic            frame_end;
    logic            pre_frame;
    logic            pat_mode;
    logic [15:0]     pix;
    logic [7:0]      lo;
    logic [PW-1:0]   pcnt;
    logic            last_px;
    logic            eop_bad;

    dvp_timing_gen #(
        .H_ACT    (H_ACT),
        .H_BLANK  (H_BLANK),
        .V_ACT    (V_ACT),
        .VS_LINES (VS_LINES),
        .V_BP     (V_BP),
        .V_FP     (V_FP)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .state     (state),
        .active    (active),
        .even      (even),
        .frame_end (frame_end)
    );

    assign pre_frame = (state == ST_IDLE) || (state == ST_VSYNC) ||
                       (state == ST_VBP);

    // Before the frame, drop stray pixels but park the sop pixel at the head
    always_comb begin
        din_rdy = 1'b0;
        if (rst) begin
            din_rdy = 1'b0;
        end else if (pat_mode) begin
            din_rdy = 1'b1;
        end else if (pre_frame) begin
            din_rdy = !(din_vld && din_sop);
        end else begin
            din_rdy = even;
        end
    end

`ifdef DVP_TX_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACT / 8 > 0) ? H_ACT / 8 : 1;
    localparam int BW    = $clog2(BAR_W + 1);

    logic [2:0]    bar_idx;
    logic [BW-1:0] bar_px;

    // vsync is registered, so state==VSYNC with vsync low is the rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_mode <= 1'b0;
            bar_idx  <= '0;
            bar_px   <= '0;
        end else begin
            if (state == ST_VSYNC && !vsync) begin
                pat_mode <= pat_en;
            end
            if (!active) begin
                bar_idx <= '0;
                bar_px  <= '0;
            end else if (even) begin
                if (bar_px == BW'(BAR_W - 1)) begin
                    bar_px  <= '0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_px <= bar_px + BW'(1);
                end
            end
        end
    end

    assign pix = pat_mode ? bar_color(bar_idx) :
                 (din_vld ? din : 16'h0000);
`else
    assign pat_mode = 1'b0;
    assign pix      = din_vld ? din : 16'h0000;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync      <= 1'b0;
            href       <= 1'b0;
            dout       <= 8'h00;
            lo         <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            vsync      <= (state == ST_VSYNC);
            frame_done <= frame_end;
            href       <= active;
            if (even) begin
                dout <= pix[15:8];
                lo   <= pix[7:0];
            end else if (active) begin
                dout <= lo;
            end else begin
                dout <= 8'h00;
            end
        end
    end

    assign last_px = (pcnt == PW'(NPIX - 1));
    assign eop_bad = din_eop ? (!last_px || (din_sop && MULTI)) : last_px;

    // Slots are counted whether or not a pixel arrived, so eop checking
    // stays tied to frame position even after an underrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt    <= '0;
            err_udr <= 1'b0;
            err_eop <= 1'b0;
        end else begin
            if (state != ST_ACT) begin
                pcnt <= '0;
            end else if (even) begin
                pcnt <= pcnt + PW'(1);
            end
            if (even && !pat_mode) begin
                if (!din_vld) begin
                    err_udr <= 1'b1;
                end else if (eop_bad) begin
                    err_eop <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dvp_tx.sv
// Directed bench for dvp_tx with a tiny 4x2 frame (8x2 with the test pattern).
`timescale 1ns/1ps
module tb_dvp_tx;

`ifdef DVP_TX_TEST_PATTERN_EN
    localparam int HA = 8;
`else
    localparam int HA = 4;
`endif
    localparam int HB   = 3;
    localparam int VA   = 2;
    localparam int VSL  = 1;
    localparam int VBPL = 1;
    localparam int VFPL = 1;
    localparam int HTOT = 2 * HA + HB;

    typedef struct {
        logic [15:0] d;
        logic        sop;
        logic        eop;
        logic        vld;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] din = 16'h0;
    logic        din_vld = 1'b0;
    logic        din_sop = 1'b0;
    logic        din_eop = 1'b0;
    logic        din_rdy, vsync, href, frame_done, err_udr, err_eop;
    logic [7:0]  dout;
`ifdef DVP_TX_TEST_PATTERN_EN
    logic        pat_en = 1'b0;
`endif

    pix_t       src[$];
    logic [7:0] bytes[$];
    int         runs[$];
    int run = 0, vs_cnt = 0, fd_cnt = 0, overlap = 0, blank_bad = 0;
    int tests = 0, fails = 0;
    logic shown = 1'b0, take = 1'b0;

    dvp_tx #(
        .H_ACT(HA), .H_BLANK(HB), .V_ACT(VA),
        .VS_LINES(VSL), .V_BP(VBPL), .V_FP(VFPL)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
`ifdef DVP_TX_TEST_PATTERN_EN
        .pat_en(pat_en),
`endif
        .din(din), .din_vld(din_vld), .din_sop(din_sop),
        .din_eop(din_eop), .din_rdy(din_rdy), .vsync(vsync),
        .href(href), .dout(dout), .frame_done(frame_done),
        .err_udr(err_udr), .err_eop(err_eop)
    );

    always #5 clk = ~clk;

    // Source: handshake judged on the settled falling edge, queue advanced after rising edge
    always @(negedge clk) take = din_rdy && shown;

    always @(posedge clk) begin
        #1;
        if (take && src.size() > 0) src.delete(0);
        take = 1'b0;
        if (src.size() > 0) begin
            din = src[0].d; din_sop = src[0].sop;
            din_eop = src[0].eop; din_vld = src[0].vld;
            shown = 1'b1;
        end else begin
            din = 16'h0; din_sop = 1'b0; din_eop = 1'b0; din_vld = 1'b0;
            shown = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (href) begin
            bytes.push_back(dout);
            run++;
        end else begin
            if (run != 0) runs.push_back(run);
            run = 0;
            if (dout !== 8'h00) blank_bad++;
        end
        if (vsync) vs_cnt++;
        if (vsync && href) overlap++;
        if (frame_done) fd_cnt++;
    end

    function automatic logic [15:0] pix(input int i);
        return 16'h1234 + 16'h1111 * i[15:0];
    endfunction

    function automatic logic [7:0] exp_byte(input int k, input int drop);
        logic [15:0] p;
        p = (k / 2 == drop) ? 16'h0000 : pix(k / 2);
        return (k % 2 == 0) ? p[15:8] : p[7:0];
    endfunction

    task automatic clear_mon();
        bytes.delete(); runs.delete();
        run = 0; vs_cnt = 0; fd_cnt = 0; overlap = 0; blank_bad = 0;
    endtask

    task automatic load_frame(input int drop, input int eop_at);
        pix_t p;
        for (int i = 0; i < HA * VA; i++) begin
            p.d = pix(i); p.sop = (i == 0); p.eop = (i == eop_at);
            p.vld = (i != drop);
            src.push_back(p);
        end
    endtask

    task automatic pulse_en();
        @(posedge clk); #1 en = 1'b1;
        @(posedge clk); #1 en = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        int start;
        start = fd_cnt;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (fd_cnt > start) ok = 1'b1;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({vsync, href, dout, frame_done} !== 11'h0) begin
            fails++;
            $display("FAIL reset_outs: got vs=%b href=%b dout=%h fd=%b, need 0",
                     vsync, href, dout, frame_done);
        end
        tests++;
        if ({err_udr, err_eop} !== 2'b00) begin
            fails++;
            $display("FAIL reset_errs: got %b%b, need 00", err_udr, err_eop);
        end
        tests++;
        if (din_rdy !== 1'b0) begin
            fails++;
            $display("FAIL reset_rdy: got %b, need 0", din_rdy);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        tests++;
        if (din_rdy !== 1'b1) begin
            fails++;
            $display("FAIL idle_rdy: got %b, need 1", din_rdy);
        end
    endtask

    task automatic check_frame(input string nm, input int drop);
        tests++;
        if (bytes.size() != 2 * HA * VA) begin
            fails++;
            $display("FAIL %s_nbytes: got %0d, need %0d", nm, bytes.size(), 2 * HA * VA);
        end else begin
            for (int k = 0; k < 2 * HA * VA; k++) begin
                tests++;
                if (bytes[k] !== exp_byte(k, drop)) begin
                    fails++;
                    $display("FAIL %s_byte%0d: got %h, need %h", nm, k, bytes[k], exp_byte(k, drop));
                end
            end
        end
        tests++;
        if (runs.size() != VA || runs[0] != 2 * HA || runs[1] != 2 * HA) begin
            fails++;
            $display("FAIL %s_href_runs: got %0d runs first=%0d, need 2 of %0d",
                     nm, runs.size(), (runs.size() > 0) ? runs[0] : -1, 2 * HA);
        end
    endtask

    task automatic test_stream();
        bit ok;
        clear_mon();
        load_frame(-1, HA * VA - 1);
        pulse_en();
        wait_done(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL stream_done: got timeout, need frame_done"); end
        check_frame("stream", -1);
        tests++;
        if (vs_cnt != HTOT * VSL) begin
            fails++; $display("FAIL stream_vsync_len: got %0d, need %0d", vs_cnt, HTOT * VSL);
        end
        tests++;
        if (fd_cnt != 1) begin fails++; $display("FAIL stream_fd: got %0d pulses, need 1", fd_cnt); end
        tests++;
        if (overlap != 0 || blank_bad != 0) begin
            fails++;
            $display("FAIL stream_blank: got overlap=%0d dout_in_blank=%0d, need 0 0", overlap, blank_bad);
        end
        tests++;
        if ({err_udr, err_eop} !== 2'b00) begin
            fails++; $display("FAIL stream_errs: got %b%b, need 00", err_udr, err_eop);
        end
    endtask

    task automatic test_flush();
        bit ok;
        pix_t p;
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            p.d = 16'hA000 + 16'(i); p.sop = 1'b0; p.eop = 1'b0; p.vld = 1'b1;
            src.push_back(p);
        end
        load_frame(-1, HA * VA - 1);
        pulse_en();
        wait_done(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL flush_done: got timeout, need frame_done"); end
        tests++;
        if (bytes.size() == 0 || bytes[0] !== 8'h12) begin
            fails++;
            $display("FAIL flush_first: got %h, need 12", (bytes.size() > 0) ? bytes[0] : 8'hxx);
        end
        check_frame("flush", -1);
        tests++;
        if (src.size() != 0 || {err_udr, err_eop} !== 2'b00) begin
            fails++;
            $display("FAIL flush_left: got %0d queued errs=%b%b, need 0 00", src.size(), err_udr, err_eop);
        end
    endtask

    task automatic test_underrun();
        bit ok;
        clear_mon();
        load_frame(2, HA * VA - 1);
        pulse_en();
        wait_done(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL udr_done: got timeout, need frame_done"); end
        check_frame("udr", 2);
        tests++;
        if ({err_udr, err_eop} !== 2'b10) begin
            fails++; $display("FAIL udr_flag: got %b%b, need 10", err_udr, err_eop);
        end
        clear_mon();
        load_frame(-1, HA * VA - 1);
        pulse_en();
        wait_done(ok);
        tests++;
        if (err_udr !== 1'b1) begin fails++; $display("FAIL udr_sticky: got %b, need 1", err_udr); end
    endtask

    task automatic test_eop();
        bit ok;
        clear_mon();
        load_frame(-1, 4);
        pulse_en();
        wait_done(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL eop_done: got timeout, need frame_done"); end
        check_frame("eop", -1);
        tests++;
        if (err_eop !== 1'b1) begin fails++; $display("FAIL eop_flag: got %b, need 1", err_eop); end
        clear_mon();
        load_frame(-1, HA * VA - 1);
        pulse_en();
        wait_done(ok);
        tests++;
        if (err_eop !== 1'b1) begin fails++; $display("FAIL eop_sticky: got %b, need 1", err_eop); end
    endtask

    task automatic test_en_rst();
        bit ok;
        clear_mon();
        load_frame(-1, HA * VA - 1);
        @(posedge clk); #1 en = 1'b1;
        for (int i = 0; i < 200 && !href; i++) @(negedge clk);
        #1 en = 1'b0;
        wait_done(ok);
        tests++;
        if (!ok || fd_cnt != 1) begin
            fails++; $display("FAIL en_drop_done: got ok=%0d pulses=%0d, need 1 1", ok, fd_cnt);
        end
        vs_cnt = 0;
        repeat (3 * HTOT) @(negedge clk);
        tests++;
        if (vs_cnt != 0) begin fails++; $display("FAIL en_drop_idle: got %0d vsync clocks, need 0", vs_cnt); end
        tests++;
        if ({err_udr, err_eop} !== 2'b11) begin
            fails++; $display("FAIL pre_rst_errs: got %b%b, need 11", err_udr, err_eop);
        end
        load_frame(-1, HA * VA - 1);
        pulse_en();
        for (int i = 0; i < 200 && !href; i++) @(negedge clk);
        #2 rst = 1'b1;
        src.delete();
        #1;
        tests++;
        if ({href, vsync, dout} !== 10'h0) begin
            fails++; $display("FAIL rst_async: got href=%b vs=%b dout=%h, need 0", href, vsync, dout);
        end
        tests++;
        if ({err_udr, err_eop, din_rdy} !== 3'b000) begin
            fails++; $display("FAIL rst_clear: got %b%b rdy=%b, need 000", err_udr, err_eop, din_rdy);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

`ifdef DVP_TX_TEST_PATTERN_EN
    task automatic test_pattern();
        bit ok;
        logic [7:0] bars [16];
        bars = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                 8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
        clear_mon();
        pat_en = 1'b1;
        pulse_en();
        wait_done(ok);
        tests++;
        if (!ok || bytes.size() != 32) begin
            fails++; $display("FAIL pat_len: got ok=%0d bytes=%0d, need 1 32", ok, bytes.size());
        end else begin
            for (int k = 0; k < 32; k++) begin
                tests++;
                if (bytes[k] !== bars[k % 16]) begin
                    fails++; $display("FAIL pat_byte%0d: got %h, need %h", k, bytes[k], bars[k % 16]);
                end
            end
        end
        tests++;
        if ({err_udr, err_eop} !== 2'b00) begin
            fails++; $display("FAIL pat_errs: got %b%b, need 00", err_udr, err_eop);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef DVP_TX_TEST_PATTERN_EN
        test_pattern();
`else
        test_stream();
        test_flush();
        test_underrun();
        test_eop();
        test_en_rst();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
